// File: rtl/bus_reg_sequencer.sv
// Byte-wide bus register front end: local address/increment/data registers,
// external register write-through, and a single-outstanding VRAM sequencer.
module bus_reg_sequencer (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        write_strobe_i,
    input  logic        read_strobe_i,
    input  logic [3:0]  reg_num_i,
    input  logic        bytesel_i,
    input  logic [7:0]  bytedata_i,
    output logic        dtack_o,
    output logic [7:0]  rd_data_o,
    output logic        reg_wr_o,
    output logic [3:0]  reg_wr_num_o,
    output logic [15:0] reg_wr_data_o,
    input  logic [15:0] reg_rd_data_i,
    output logic        vram_req_o,
    output logic        vram_wr_o,
    output logic [15:0] vram_addr_o,
    output logic [15:0] vram_data_o,
    input  logic        vram_ack_i,
    input  logic [15:0] vram_data_i
);
    localparam logic [3:0] REG_RD_ADDR = 4'd2;
    localparam logic [3:0] REG_WR_ADDR = 4'd3;
    localparam logic [3:0] REG_INCR    = 4'd4;
    localparam logic [3:0] REG_DATA    = 4'd5;

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ} state_t;

    state_t      state;
    logic [7:0]  hold;
    logic [15:0] rd_addr, wr_addr, incr, rd_word;
    logic        pend_valid, pend_wr, pend_sel;
    logic [15:0] pend_data;
    logic        prefetch_want, rd_stale, own, ext_rd, ext_sel;

    logic [15:0] commit_word, int_word;
    logic        accept, busy, ack_now, start_pf;

    function automatic logic [7:0] pick(input logic [15:0] w, input logic sel);
        return sel ? w[7:0] : w[15:8];
    endfunction

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        commit_word = {hold, bytedata_i};
        accept      = (write_strobe_i || read_strobe_i) && !pend_valid;
        busy        = (state != IDLE) || pend_valid || prefetch_want;
        ack_now     = vram_ack_i && (state != IDLE);
        start_pf    = (state == IDLE) && prefetch_want;
        case (reg_num_i)
            REG_RD_ADDR: int_word = rd_addr;
            REG_WR_ADDR: int_word = wr_addr;
            REG_INCR:    int_word = incr;
            default:     int_word = rd_word;
        endcase
    end

    // NOTE: later non-blocking assignments win, so strobe handling is placed last to override.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state <= IDLE;
            hold <= '0; rd_addr <= '0; wr_addr <= '0; incr <= 16'd1; rd_word <= '0;
            pend_valid <= 1'b0; pend_wr <= 1'b0; pend_sel <= 1'b0; pend_data <= '0;
            prefetch_want <= 1'b0; rd_stale <= 1'b0; own <= 1'b0;
            ext_rd <= 1'b0; ext_sel <= 1'b0;
            dtack_o <= 1'b0; rd_data_o <= '0;
            reg_wr_o <= 1'b0; reg_wr_num_o <= '0; reg_wr_data_o <= '0;
            vram_req_o <= 1'b0; vram_wr_o <= 1'b0; vram_addr_o <= '0; vram_data_o <= '0;
        end else begin
            reg_wr_o <= 1'b0;

            if (ext_rd) begin
                rd_data_o <= pick(reg_rd_data_i, ext_sel);
                dtack_o   <= 1'b1;
                ext_rd    <= 1'b0;
            end

            if (ack_now) begin
                state      <= IDLE;
                vram_req_o <= 1'b0;
                if (state == WR_REQ) begin
                    wr_addr <= wr_addr + incr;
                    if (own) dtack_o <= 1'b1;
                end else if (!rd_stale) begin
                    rd_word <= vram_data_i;
                    rd_addr <= rd_addr + incr;
                end
                rd_stale <= 1'b0;
                own      <= 1'b0;
            end

            // Idle scheduler: a queued prefetch is older than anything in the pending slot.
            if (state == IDLE) begin
                if (prefetch_want) begin
                    prefetch_want <= 1'b0;
                    state <= RD_REQ; vram_req_o <= 1'b1; vram_wr_o <= 1'b0; vram_addr_o <= rd_addr;
                end else if (pend_valid) begin
                    pend_valid <= 1'b0;
                    if (pend_wr) begin
                        own <= 1'b1;
                        state <= WR_REQ; vram_req_o <= 1'b1; vram_wr_o <= 1'b1;
                        vram_addr_o <= wr_addr; vram_data_o <= pend_data;
                    end else begin
                        rd_data_o <= pick(rd_word, pend_sel);
                        dtack_o   <= 1'b1;
                        if (pend_sel) begin
                            state <= RD_REQ; vram_req_o <= 1'b1; vram_wr_o <= 1'b0; vram_addr_o <= rd_addr;
                        end
                    end
                end
            end

            if (accept) begin
                own    <= 1'b0;
                ext_rd <= 1'b0;
                if (write_strobe_i) begin
                    dtack_o <= 1'b1;
                    if (!bytesel_i) begin
                        hold <= bytedata_i;
                    end else begin
                        case (reg_num_i)
                            REG_RD_ADDR: begin
                                rd_addr       <= commit_word;
                                prefetch_want <= 1'b1;
                                // An in-flight prefetch now targets a superseded address.
                                if ((state == RD_REQ && !ack_now) || start_pf) rd_stale <= 1'b1;
                            end
                            REG_WR_ADDR: wr_addr <= commit_word;
                            REG_INCR:    incr    <= commit_word;
                            REG_DATA: begin
                                dtack_o <= 1'b0;
                                if (busy) begin
                                    pend_valid <= 1'b1; pend_wr <= 1'b1; pend_data <= commit_word;
                                end else begin
                                    own <= 1'b1;
                                    state <= WR_REQ; vram_req_o <= 1'b1; vram_wr_o <= 1'b1;
                                    vram_addr_o <= wr_addr; vram_data_o <= commit_word;
                                end
                            end
                            default: begin
                                reg_wr_o      <= 1'b1;
                                reg_wr_num_o  <= reg_num_i;
                                reg_wr_data_o <= commit_word;
                            end
                        endcase
                    end
                end else begin
                    case (reg_num_i)
                        REG_DATA: begin
                            if (busy) begin
                                pend_valid <= 1'b1; pend_wr <= 1'b0; pend_sel <= bytesel_i;
                                dtack_o    <= 1'b0;
                            end else begin
                                rd_data_o <= pick(rd_word, bytesel_i);
                                dtack_o   <= 1'b1;
                                if (bytesel_i) begin
                                    state <= RD_REQ; vram_req_o <= 1'b1; vram_wr_o <= 1'b0; vram_addr_o <= rd_addr;
                                end
                            end
                        end
                        REG_RD_ADDR, REG_WR_ADDR, REG_INCR: begin
                            rd_data_o <= pick(int_word, bytesel_i);
                            dtack_o   <= 1'b1;
                        end
                        default: begin
                            // External readback is sampled one cycle after the strobe.
                            ext_rd  <= 1'b1;
                            ext_sel <= bytesel_i;
                            dtack_o <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_bus_reg_sequencer.sv
// Directed self-checking bench for bus_reg_sequencer.
module tb_bus_reg_sequencer;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        write_strobe_i = 1'b0, read_strobe_i = 1'b0;
    logic [3:0]  reg_num_i = '0;
    logic        bytesel_i = 1'b0;
    logic [7:0]  bytedata_i = '0;
    logic        dtack_o;
    logic [7:0]  rd_data_o;
    logic        reg_wr_o;
    logic [3:0]  reg_wr_num_o;
    logic [15:0] reg_wr_data_o;
    logic [15:0] reg_rd_data_i = '0;
    logic        vram_req_o, vram_wr_o;
    logic [15:0] vram_addr_o, vram_data_o;
    logic        vram_ack_i = 1'b0;
    logic [15:0] vram_data_i = '0;

    int checks = 0;
    int errors = 0;

    bus_reg_sequencer dut (
        .clk(clk), .reset_i(reset_i),
        .write_strobe_i(write_strobe_i), .read_strobe_i(read_strobe_i),
        .reg_num_i(reg_num_i), .bytesel_i(bytesel_i), .bytedata_i(bytedata_i),
        .dtack_o(dtack_o), .rd_data_o(rd_data_o),
        .reg_wr_o(reg_wr_o), .reg_wr_num_o(reg_wr_num_o), .reg_wr_data_o(reg_wr_data_o),
        .reg_rd_data_i(reg_rd_data_i),
        .vram_req_o(vram_req_o), .vram_wr_o(vram_wr_o),
        .vram_addr_o(vram_addr_o), .vram_data_o(vram_data_o),
        .vram_ack_i(vram_ack_i), .vram_data_i(vram_data_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] r, input logic s, input logic [7:0] d);
        write_strobe_i = 1'b1; reg_num_i = r; bytesel_i = s; bytedata_i = d;
        tick();
        write_strobe_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] r, input logic s);
        read_strobe_i = 1'b1; reg_num_i = r; bytesel_i = s;
        tick();
        read_strobe_i = 1'b0;
    endtask

    task automatic ack(input logic [15:0] d);
        vram_ack_i = 1'b1; vram_data_i = d;
        tick();
        vram_ack_i = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (vram_req_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(tag, seen, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        check("rst_dtack", dtack_o, 0);
        check("rst_req", vram_req_o, 0);
        check("rst_vwr", vram_wr_o, 0);
        check("rst_regwr", reg_wr_o, 0);
        check("rst_addr", vram_addr_o, 16'h0000);
        check("rst_rdata", rd_data_o, 8'h00);
        reset_i = 1'b0;
        rd(4'd4, 1'b1);
        check("rst_incr_lo", rd_data_o, 8'h01);
        check("rst_incr_dtack", dtack_o, 1);

        // External register write
        wr(4'd9, 1'b0, 8'h12);
        check("ext_even_dtack", dtack_o, 1);
        check("ext_even_nowr", reg_wr_o, 0);
        wr(4'd9, 1'b1, 8'h34);
        check("ext_wr_pulse", reg_wr_o, 1);
        check("ext_wr_num", reg_wr_num_o, 4'd9);
        check("ext_wr_data", reg_wr_data_o, 16'h1234);
        check("ext_odd_dtack", dtack_o, 1);
        tick();
        check("ext_wr_one_cycle", reg_wr_o, 0);

        // DATA write with WR_ADDR wrap
        wr(4'd3, 1'b0, 8'hFF); wr(4'd3, 1'b1, 8'hFF);
        wr(4'd4, 1'b0, 8'h00); wr(4'd4, 1'b1, 8'h02);
        wr(4'd5, 1'b0, 8'hBE); wr(4'd5, 1'b1, 8'hEF);
        check("dw_dtack0", dtack_o, 0);
        check("dw_req", vram_req_o, 1);
        check("dw_wr", vram_wr_o, 1);
        check("dw_addr", vram_addr_o, 16'hFFFF);
        check("dw_data", vram_data_o, 16'hBEEF);
        tick(); tick();
        check("dw_hold_req", vram_req_o, 1);
        check("dw_hold_addr", vram_addr_o, 16'hFFFF);
        check("dw_hold_dtack", dtack_o, 0);
        ack(16'h0000);
        check("dw_req_drop", vram_req_o, 0);
        check("dw_done_dtack", dtack_o, 1);
        rd(4'd3, 1'b0);
        check("dw_wraddr_hi", rd_data_o, 8'h00);
        rd(4'd3, 1'b1);
        check("dw_wraddr_lo", rd_data_o, 8'h01);

        // RD_ADDR load, prefetch and DATA reads
        wr(4'd4, 1'b0, 8'h00); wr(4'd4, 1'b1, 8'h01);
        wr(4'd2, 1'b0, 8'h01); wr(4'd2, 1'b1, 8'h00);
        check("ra_dtack", dtack_o, 1);
        wait_req("pf_req_seen");
        check("pf_rd", vram_wr_o, 0);
        check("pf_addr", vram_addr_o, 16'h0100);
        ack(16'hA5C3);
        rd(4'd5, 1'b0);
        check("data_even", rd_data_o, 8'hA5);
        check("data_even_dtack", dtack_o, 1);
        rd(4'd5, 1'b1);
        check("data_odd", rd_data_o, 8'hC3);
        check("next_pf_req", vram_req_o, 1);
        check("next_pf_addr", vram_addr_o, 16'h0101);
        ack(16'h1111);
        rd(4'd2, 1'b1);
        check("rdaddr_lo", rd_data_o, 8'h02);

        // Back-to-back DATA writes through the pending slot
        wr(4'd3, 1'b0, 8'h00); wr(4'd3, 1'b1, 8'h10);
        wr(4'd5, 1'b0, 8'hAA); wr(4'd5, 1'b1, 8'h01);
        check("b2b_first_addr", vram_addr_o, 16'h0010);
        wr(4'd5, 1'b0, 8'hBB);
        wr(4'd5, 1'b1, 8'h02);
        check("b2b_pend_dtack", dtack_o, 0);
        check("b2b_first_stable", vram_data_o, 16'hAA01);
        ack(16'h0000);
        check("b2b_mid_dtack", dtack_o, 0);
        tick();
        check("b2b_second_req", vram_req_o, 1);
        check("b2b_second_addr", vram_addr_o, 16'h0011);
        check("b2b_second_data", vram_data_o, 16'hBB02);
        check("b2b_second_dtack", dtack_o, 0);
        ack(16'h0000);
        check("b2b_done_dtack", dtack_o, 1);
        rd(4'd3, 1'b1);
        check("b2b_wraddr_lo", rd_data_o, 8'h12);

        // External readback sampled one cycle after the strobe
        reg_rd_data_i = 16'h5AC3;
        rd(4'd7, 1'b0);
        check("xrd_wait", dtack_o, 0);
        tick();
        check("xrd_data", rd_data_o, 8'h5A);
        check("xrd_dtack", dtack_o, 1);

        // Stray ack while idle
        ack(16'hFFFF);
        check("idle_ack_req", vram_req_o, 0);
        rd(4'd3, 1'b1);
        check("idle_ack_wraddr", rd_data_o, 8'h12);

        // DATA read waiting on an outstanding prefetch
        wr(4'd2, 1'b0, 8'h02); wr(4'd2, 1'b1, 8'h00);
        rd(4'd5, 1'b0);
        check("wait_rd_dtack", dtack_o, 0);
        check("wait_rd_req", vram_req_o, 1);
        check("wait_rd_addr", vram_addr_o, 16'h0200);
        ack(16'h9876);
        check("wait_rd_mid", dtack_o, 0);
        tick();
        check("wait_rd_data", rd_data_o, 8'h98);
        check("wait_rd_done", dtack_o, 1);

        // Reset mid-access, then a late ack
        wr(4'd5, 1'b0, 8'h77); wr(4'd5, 1'b1, 8'h88);
        check("mid_req", vram_req_o, 1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("mr_req", vram_req_o, 0);
        check("mr_dtack", dtack_o, 0);
        check("mr_addr", vram_addr_o, 16'h0000);
        check("mr_vdata", vram_data_o, 16'h0000);
        check("mr_wrdata", reg_wr_data_o, 16'h0000);
        ack(16'h1234);
        check("mr_late_req", vram_req_o, 0);
        rd(4'd3, 1'b1);
        check("mr_wraddr", rd_data_o, 8'h00);
        rd(4'd2, 1'b1);
        check("mr_rdaddr", rd_data_o, 8'h00);
        rd(4'd5, 1'b0);
        check("mr_rdword", rd_data_o, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_reg_sequencer.md
BUS_REG_SEQUENCER -- requirements
Module: bus_reg_sequencer

Interface
REQ-001 SHALL have these ports: clk  in  1  system clock.
REQ-002 SHALL have: reset_i  in  1  reset (synchronous, active-high).
REQ-003 SHALL have: write_strobe_i / read_strobe_i  in  1 each  one-cycle access strobes from bus_interface.
REQ-004 SHALL have: reg_num_i  in  4  register number; bytesel_i  in  1  0=even (high) byte, 1=odd (low) byte; bytedata_i  in  8  write byte.
REQ-005 SHALL have: dtack_o  out  1  1=access complete, feeds bus_interface bus_dtack_i; rd_data_o  out  8  read byte.
REQ-006 SHALL have: reg_wr_o  out  1  external register write pulse; reg_wr_num_o  out  4; reg_wr_data_o  out  16; reg_rd_data_i  in  16  external register readback.
REQ-007 SHALL have: vram_req_o  out  1; vram_wr_o  out  1  1=write; vram_addr_o  out  16; vram_data_o  out  16; vram_ack_i  in  1  one-cycle grant/complete; vram_data_i  in  16  read data, valid with vram_ack_i.
REQ-008 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-009 Internal registers SHALL be: 2=RD_ADDR, 3=WR_ADDR, 4=INCR, 5=DATA; all others external.
REQ-010 Even-byte write SHALL latch bytedata_i into an 8-bit hold register only; no other effect; dtack_o=1 next cycle.
REQ-011 Odd-byte write SHALL commit {hold, bytedata_i} as a 16-bit word; hold is not cleared.
REQ-012 External commit SHALL pulse reg_wr_o exactly one cycle at strobe+1, with reg_wr_num_o/reg_wr_data_o valid that cycle; dtack_o=1 same cycle.
REQ-013 RD_ADDR commit SHALL load RD_ADDR and start a prefetch read at the new address.
REQ-014 DATA commit SHALL start a VRAM write of the word at WR_ADDR; WR_ADDR += INCR (mod 2^16) on vram_ack_i.
REQ-015 Prefetch completion SHALL capture vram_data_i into a 16-bit read word; RD_ADDR += INCR (mod 2^16) at the same edge.
REQ-016 Reads SHALL return bytesel_i ? word[7:0] : word[15:8]; word = read word (DATA), internal register value (2-4), or reg_rd_data_i (others, sampled at strobe+1).
REQ-017 Odd-byte read of DATA SHALL start the next prefetch after returning its byte.
REQ-018 FSM states SHALL be IDLE, WR_REQ, RD_REQ; IDLE->WR_REQ on DATA commit; IDLE->RD_REQ on prefetch start; WR_REQ/RD_REQ->IDLE on vram_ack_i.
REQ-019 vram_req_o SHALL assert the cycle after entry to WR_REQ/RD_REQ and hold, with stable addr/data/wr, until vram_ack_i; deassert the cycle after.
REQ-020 VRAM accesses SHALL complete in issue order; at most one outstanding VRAM access, plus one pending slot.
REQ-021 A DATA commit or DATA read arriving while not IDLE SHALL occupy the pending slot, with dtack_o held 0 until it is serviced.
REQ-022 A DATA read while a prefetch is outstanding SHALL wait for that prefetch, then return the fresh byte.
REQ-023 DATA write completion: dtack_o=1 the cycle after vram_ack_i. DATA read completion: dtack_o=1 when rd_data_o is valid.
REQ-024 dtack_o SHALL stay 1 until the next strobe, then drop to 0 the following cycle unless that access also completes in one cycle.
REQ-025 Strobes arriving while the pending slot is full SHALL be ignored. (Bus protocol forbids this, because dtack is withheld.)
REQ-026 vram_ack_i while IDLE SHALL be ignored.

Reset
REQ-027 Reset SHALL force IDLE, and set dtack_o=0, vram_req_o=0, vram_wr_o=0, reg_wr_o=0.
REQ-028 Reset SHALL clear pending slot, hold, RD_ADDR, WR_ADDR and read word to 0, with INCR=1.
REQ-029 Reset SHALL zero vram_addr_o, vram_data_o, reg_wr_num_o, reg_wr_data_o and rd_data_o.
REQ-030 Reset mid-access SHALL abandon the access; a late vram_ack_i after reset is ignored.

Verification
REQ-031 Write reg 9: even 0x12, then odd 0x34 -> one reg_wr_o pulse, num=9, data=0x1234; dtack_o=1 both accesses.
REQ-032 WR_ADDR=0xFFFF, INCR=2, DATA write 0xBEEF, ack 3 cycles after req -> vram_wr_o=1, addr=0xFFFF; WR_ADDR becomes 0x0001.
REQ-033 RD_ADDR write 0x0100, vram_data_i=0xA5C3 on ack -> DATA even read=0xA5, odd read=0xC3; next prefetch at 0x0101.
REQ-034 DATA write issued while previous DATA write unacked -> dtack_o=0 until both complete; two requests in order, WR_ADDR advanced twice.
REQ-035 Assert reset_i while vram_req_o=1, then pulse vram_ack_i -> outputs at reset values; RD_ADDR/WR_ADDR stay 0.
